// File: rtl/dual_writer_merge_pkg.sv
// Shared encodings for the two-writer merge register: source IDs and
// round-robin arbiter states.
package dual_writer_merge_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    FAV_A = 1'b0,
    FAV_B = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dual_writer_merge_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_count <= '0;
    else if (inc && (r_count != {WIDTH{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/dual_writer_merge.sv
// Two-writer merge register: round-robin arbitration picks one write per
// cycle; a single sequential process owns the stored value.
module dual_writer_merge
  import dual_writer_merge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_src,
  output logic             q_upd,
  output logic [CNT_W-1:0] conflict_cnt
);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic [WIDTH-1:0] w_data;
  logic             w_src;
  logic [WIDTH-1:0] r_q;
  logic             r_src;
  logic             r_upd;

  // Grants depend only on valids, reset and state; data just follows the grant.
  always_comb begin
    w_gnt_a     = 1'b0;
    w_gnt_b     = 1'b0;
    w_state_nxt = r_state;
    w_data      = a_data;
    w_src       = SRC_A;
    if (!reset) begin
      if (a_valid && (!b_valid || r_state == FAV_A))
        w_gnt_a = 1'b1;
      else if (b_valid)
        w_gnt_b = 1'b1;
    end
    if (w_gnt_a) begin
      w_state_nxt = FAV_B;
    end else if (w_gnt_b) begin
      w_state_nxt = FAV_A;
      w_data      = b_data;
      w_src       = SRC_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FAV_A;
      r_q     <= '0;
      r_src   <= SRC_A;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_upd   <= w_gnt_a | w_gnt_b;
      if (w_gnt_a | w_gnt_b) begin
        r_q   <= w_data;
        r_src <= w_src;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (a_valid & b_valid),
    .count (conflict_cnt)
  );

  assign a_ready = w_gnt_a;
  assign b_ready = w_gnt_b;
  assign q       = r_q;
  assign q_src   = r_src;
  assign q_upd   = r_upd;

endmodule

// File: tb/tb_dual_writer_merge.sv
// Randomized + directed bench for dual_writer_merge against a cycle-level
// reference model; a second instance with a 2-bit counter exercises saturation.
module tb_dual_writer_merge;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             a_valid, b_valid;
  logic [WIDTH-1:0] a_data, b_data;

  logic             a_ready, b_ready, q_src, q_upd;
  logic [WIDTH-1:0] q;
  logic [7:0]       conflict_cnt;

  logic             s_a_ready, s_b_ready, s_q_src, s_q_upd;
  logic [WIDTH-1:0] s_q;
  logic [1:0]       s_conflict_cnt;

  dual_writer_merge #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .q(q), .q_src(q_src), .q_upd(q_upd), .conflict_cnt(conflict_cnt)
  );

  dual_writer_merge #(.WIDTH(WIDTH), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(s_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(s_b_ready),
    .q(s_q), .q_src(s_q_src), .q_upd(s_q_upd), .conflict_cnt(s_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: "next favoured" is B right after an A grant, A otherwise.
  bit         m_next_b;
  logic [7:0] m_q;
  bit         m_src, m_upd;
  int         m_cnt, m_cnt_s;
  bit         e_ga, e_gb;

  task automatic model_reset();
    m_next_b = 0; m_q = '0; m_src = 0; m_upd = 0; m_cnt = 0; m_cnt_s = 0;
  endtask

  // One clock: check readies before the edge, advance model, check state after.
  task automatic cyc();
    logic [7:0] prev_q;
    bit         was_rst;
    #1;
    e_ga = !reset && a_valid && (!b_valid || !m_next_b);
    e_gb = !reset && b_valid && !e_ga;
    chk("a_ready", a_ready, e_ga);
    chk("b_ready", b_ready, e_gb);
    chk("s_a_ready", s_a_ready, e_ga);
    chk("one_ready", a_ready & b_ready, 0);
    prev_q  = q;
    was_rst = reset;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_upd = e_ga || e_gb;
      if (e_ga) begin m_q = a_data; m_src = 0; m_next_b = 1; end
      if (e_gb) begin m_q = b_data; m_src = 1; m_next_b = 0; end
      if (a_valid && b_valid) begin
        m_cnt   = (m_cnt   < 255) ? m_cnt + 1   : 255;
        m_cnt_s = (m_cnt_s < 3)   ? m_cnt_s + 1 : 3;
      end
    end
    #1;
    chk("q", q, m_q);
    chk("q_src", q_src, m_src);
    chk("q_upd", q_upd, m_upd);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("s_conflict_cnt", s_conflict_cnt, m_cnt_s);
    chk("s_q", s_q, m_q);
    if (!was_rst && !q_upd) chk("q_hold", q, prev_q);
  endtask

  task automatic drive(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
  endtask

  task automatic do_reset();
    reset = 1'b1; drive(0, 8'h00, 0, 8'h00);
    cyc();
    reset = 1'b0;
  endtask

  logic [1:0] sat_exp [6];

  initial begin
    reset = 1'b1;
    drive(0, 8'h00, 0, 8'h00);
    model_reset();
    cyc(); cyc();
    chk("rst_q", q, 0);
    chk("rst_cnt", conflict_cnt, 0);
    reset = 1'b0;

    // A only for one cycle
    drive(1, 8'h3C, 0, 8'h00);
    #1 chk("t1_a_ready", a_ready, 1);
    cyc();
    drive(0, 8'h00, 0, 8'h00);
    chk("t1_q", q, 8'h3C); chk("t1_src", q_src, 0); chk("t1_upd", q_upd, 1);
    cyc();
    chk("t1_upd_low", q_upd, 0);

    // Both valid 4 cycles: A,B,A,B
    do_reset();
    drive(1, 8'h0F, 1, 8'hF0);
    cyc(); chk("t2_q0", q, 8'h0F);
    cyc(); chk("t2_q1", q, 8'hF0);
    cyc(); chk("t2_q2", q, 8'h0F);
    cyc(); chk("t2_q3", q, 8'hF0);
    chk("t2_cnt", conflict_cnt, 4);
    drive(0, 8'h00, 0, 8'h00);
    cyc();

    // Favour survives idle cycles
    do_reset();
    drive(0, 8'h00, 1, 8'h11);
    cyc(); chk("t3_q", q, 8'h11); chk("t3_src", q_src, 1);
    drive(0, 8'h00, 0, 8'h00);
    cyc(); cyc(); cyc();
    drive(1, 8'h22, 1, 8'h33);
    #1 chk("t3_a_first", a_ready, 1);
    cyc(); chk("t3_q2", q, 8'h22);

    // Saturation on the 2-bit counter
    do_reset();
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    drive(1, 8'hA5, 1, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t4_sat", s_conflict_cnt, sat_exp[i]);
    end

    // Reset mid-stream
    do_reset();
    drive(1, 8'h44, 1, 8'h55);
    cyc();
    reset = 1'b1;
    #1 chk("t5_no_ready", a_ready | b_ready, 0);
    cyc();
    chk("t5_q", q, 0); chk("t5_cnt", conflict_cnt, 0);
    reset = 1'b0;
    #1 chk("t5_a_next", a_ready, 1);
    cyc();

    // Random traffic; a pending unaccepted write keeps its data stable
    for (int i = 0; i < 3000; i++) begin
      bit keep_a, keep_b;
      keep_a = a_valid && !e_ga && !reset;
      keep_b = b_valid && !e_gb && !reset;
      if (!keep_a) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_data  = 8'($urandom);
      end
      if (!keep_b) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_data  = 8'($urandom);
      end
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;
    drive(0, 8'h00, 0, 8'h00);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_writer_merge.md
# dual_writer_merge

Single-owner merge register that accepts write requests from two independent sources and commits exactly one per cycle into one output register. It is the legal-hardware counterpart to driving one variable from two always blocks: both writers connect here, a round-robin arbiter decides ownership, and only this block's single sequential process drives the stored value. It sits between any two producers and a shared downstream register consumer.

## Interface
- WIDTH, 8, data width of each writer and of the stored value
- CNT_W, 8, width of the saturating conflict counter
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- a_valid  input  1  writer A has a write pending
- a_data  input  WIDTH  writer A data; stable while a_valid high
- a_ready  output  1  writer A write accepted this cycle
- b_valid  input  1  writer B has a write pending
- b_data  input  WIDTH  writer B data; stable while b_valid high
- b_ready  output  1  writer B write accepted this cycle
- q  output  WIDTH  stored value (registered)
- q_src  output  1  source of last committed write: 0 = A, 1 = B
- q_upd  output  1  one-cycle pulse, high the cycle after a commit
- conflict_cnt  output  CNT_W  count of cycles where both writers were valid

## Operation
- Transfer on a source = valid & ready in the same cycle; at most one of a_ready/b_ready high per cycle.
- Arbiter state (registered): FAV_A, FAV_B. Reset state FAV_A.
- Grant rule: only A valid -> A; only B valid -> B; both valid -> favoured source; neither -> no grant, ready both 0.
- State transitions: after grant to A -> FAV_B; after grant to B -> FAV_A; no grant -> state unchanged.
- Consequence: with both valid continuously, grants alternate A, B, A, B...; neither writer starves longer than one cycle.
- Commit: on a transfer, next edge loads q <= granted data, q_src <= granted source, q_upd <= 1; otherwise q, q_src hold and q_upd <= 0.
- conflict_cnt increments by 1 on each edge where a_valid & b_valid; saturates at 2^CNT_W-1 (no wrap).
- A writer whose valid stays high after acceptance issues a new write; the block does not deduplicate.

## Timing
- a_ready/b_ready are combinational from a_valid, b_valid and arbiter state; no path from data inputs.
- Latency: accepted data visible on q exactly 1 cycle after the accepting edge; q_upd coincides.
- Throughput: one commit per cycle sustained.
- Reset (synchronous, dominates all): q = 0, q_src = 0, q_upd = 0, conflict_cnt = 0, state FAV_A. During reset cycle ready outputs are 0 and no transfer occurs.
- Reset mid-stream: a write presented in the reset cycle is dropped; writer must re-present it afterward.
- Reset and conflict in same cycle: counter reads 0 after the edge.

## Structure
- Shared package: source encoding constants SRC_A = 0, SRC_B = 1; arbiter state encoding FAV_A/FAV_B.
- Sub-module: sat_counter (parameter WIDTH; ports clk, reset, inc, count) used for conflict_cnt.
- All of q, q_src, q_upd and arbiter state written in one sequential process only; grant logic in one combinational process.

## Test plan
- Reset then A only: a_valid=1, a_data=0x3C for one cycle -> a_ready=1, next cycle q=0x3C, q_src=0, q_upd=1, following cycle q_upd=0.
- Simultaneous after reset: a_data=0x0F, b_data=0xF0 both valid 4 cycles -> grants A,B,A,B; q sequence 0x0F,0xF0,0x0F,0xF0; conflict_cnt=4.
- Priority memory: grant B alone (b_data=0x11), idle 3 cycles, then both valid -> A wins first (state FAV_A held through idle).
- Saturation with CNT_W=2: both valid 6 cycles -> conflict_cnt 1,2,3,3,3,3.
- Reset mid-stream: both valid, assert reset on cycle 2 -> that cycle no ready, q=0, conflict_cnt=0, next grant goes to A.
- Invariant check every cycle: never a_ready & b_ready; q changes only when q_upd high.
